// File: rtl/alu_uart_pkg.sv
// Shared opcodes, parser state encoding and datapath width for the UART ALU frame parser.
// ALU_MUL_EN (see alu_op_unit) decides whether OP_MUL is a recognised opcode.
package alu_uart_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hAD;
    localparam logic [7:0] OP_MUL  = 8'h88;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LEN_LO    = 3'd1,
        ST_LEN_HI    = 3'd2,
        ST_OPERAND   = 3'd3,
        ST_ECHO_FWD  = 3'd4,
        ST_RESULT_TX = 3'd5,
        ST_DRAIN     = 3'd6
    } state_t;

    function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/alu_op_unit.sv
// Combinational accumulate step: result = acc op word (mod 2^32), zero latency, no flow control.
// MUL path only exists when ALU_MUL_EN is defined; otherwise no multiplier is built.
module alu_op_unit
    import alu_uart_pkg::*;
(
    input  logic [7:0]        op_i,
    input  logic [WORD_W-1:0] acc_i,
    input  logic [WORD_W-1:0] word_i,
    output logic [WORD_W-1:0] result_o
);

    always_comb begin
        result_o = acc_i;
        case (op_i)
            OP_ADD: result_o = acc_i + word_i;
`ifdef ALU_MUL_EN
            OP_MUL: result_o = acc_i * word_i;
`else
`endif
            default: result_o = acc_i;
        endcase
    end

endmodule

// File: rtl/alu_frame_parser.sv
// UART frame parser: ECHO forwards payload, ADD/MUL (MUL with ALU_MUL_EN) fold 32-bit LE words and send the 4-byte result.
// Latency: echoed byte / first result byte valid one cycle after the accepting (last) rx byte.
// Backpressure: rx_ready_o drops while the one-entry tx register is full (echo) or while the result is sent.
module alu_frame_parser
    import alu_uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 3225600
)
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       err_o
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [7:0]          op_q, op_d;
    logic [15:0]         len_q, len_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [23:0]         word_q, word_d;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic                first_q, first_d;
    logic [7:0]          tx_dat_q, tx_dat_d;
    logic                tx_vld_q, tx_vld_d;
    logic [2:0]          tx_idx_q, tx_idx_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                err_q, err_d;

    logic                rx_rdy;
    logic                byte_get;
    logic                tx_free;
    logic                is_alu;
    logic [15:0]         cnt_inc;
    logic [15:0]         new_len;
    logic [WORD_W-1:0]   full_word;
    logic [WORD_W-1:0]   op_result;

    assign full_word = {rx_data_i, word_q};
    assign cnt_inc   = cnt_q + 16'd1;
    assign new_len   = {rx_data_i, len_q[7:0]};
    assign tx_free   = !tx_vld_q || tx_ready_i;
    assign byte_get  = rx_valid_i && rx_rdy;

`ifdef ALU_MUL_EN
    assign is_alu = (op_q == OP_ADD) || (op_q == OP_MUL);
`else
    assign is_alu = (op_q == OP_ADD);
`endif

    alu_op_unit u_op (
        .op_i     (op_q),
        .acc_i    (acc_q),
        .word_i   (full_word),
        .result_o (op_result)
    );

    // Echo stops accepting once LEN bytes are in, so the next frame waits for the last forward.
    always_comb begin
        rx_rdy = 1'b1;
        case (state_q)
            ST_RESULT_TX: rx_rdy = 1'b0;
            ST_ECHO_FWD:  rx_rdy = (cnt_q != len_q) && tx_free;
            default:      rx_rdy = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        acc_d    = acc_q;
        first_d  = first_q;
        tx_dat_d = tx_dat_q;
        tx_vld_d = tx_vld_q && !tx_ready_i;
        tx_idx_d = tx_idx_q;
        tmo_d    = tmo_q;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (byte_get) begin
                    op_d    = rx_data_i;
                    len_d   = 16'd0;
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (byte_get) begin
                    len_d[7:0] = rx_data_i;
                    state_d    = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (byte_get) begin
                    len_d   = new_len;
                    cnt_d   = 16'd0;
                    first_d = 1'b1;
                    if (op_q == OP_ECHO) begin
                        state_d = (new_len == 16'd0) ? ST_IDLE : ST_ECHO_FWD;
                    end else if (is_alu && (new_len != 16'd0) && (new_len[1:0] == 2'b00)) begin
                        state_d = ST_OPERAND;
                    end else begin
                        err_d   = 1'b1;
                        state_d = (new_len == 16'd0) ? ST_IDLE : ST_DRAIN;
                    end
                end
            end
            ST_OPERAND: begin
                if (byte_get) begin
                    word_d = full_word[31:8];
                    cnt_d  = cnt_inc;
                    if (cnt_q[1:0] == 2'd3) begin
                        acc_d   = first_q ? full_word : op_result;
                        first_d = 1'b0;
                    end
                    if (cnt_inc == len_q) begin
                        state_d = ST_RESULT_TX;
                        // A late echo byte may still occupy the register; RESULT_TX then loads byte 0.
                        if (tx_free) begin
                            tx_dat_d = acc_d[7:0];
                            tx_vld_d = 1'b1;
                            tx_idx_d = 3'd1;
                        end else begin
                            tx_idx_d = 3'd0;
                        end
                    end
                end
            end
            ST_RESULT_TX: begin
                if (tx_free) begin
                    if (tx_idx_q == 3'd4) begin
                        state_d = ST_IDLE;
                    end else begin
                        tx_dat_d = word_byte(acc_q, tx_idx_q[1:0]);
                        tx_vld_d = 1'b1;
                        tx_idx_d = tx_idx_q + 3'd1;
                    end
                end
            end
            ST_ECHO_FWD: begin
                if (byte_get) begin
                    tx_dat_d = rx_data_i;
                    tx_vld_d = 1'b1;
                    cnt_d    = cnt_inc;
                end else if ((cnt_q == len_q) && tx_free) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (byte_get) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Inter-byte timeout; a pending echo byte survives because tx_vld_q is left alone.
        if ((state_q == ST_IDLE) || (state_q == ST_RESULT_TX) || byte_get) begin
            tmo_d = '0;
        end else if (rx_rdy && !rx_valid_i) begin
            if (tmo_q == TMO_LAST) begin
                tmo_d   = '0;
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            op_q     <= 8'd0;
            len_q    <= 16'd0;
            cnt_q    <= 16'd0;
            word_q   <= 24'd0;
            acc_q    <= '0;
            first_q  <= 1'b1;
            tx_dat_q <= 8'd0;
            tx_vld_q <= 1'b0;
            tx_idx_q <= 3'd0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            acc_q    <= acc_d;
            first_q  <= first_d;
            tx_dat_q <= tx_dat_d;
            tx_vld_q <= tx_vld_d;
            tx_idx_q <= tx_idx_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
        end
    end

    assign rx_ready_o = rx_rdy;
    assign tx_data_o  = tx_dat_q;
    assign tx_valid_o = tx_vld_q;
    assign err_o      = err_q;

endmodule

// File: doc/alu_frame_parser.md
ALU_FRAME_PARSER -- requirements
Module: alu_frame_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 3225600, meaning max idle cycles between frame bytes (100 ms at 32.256 MHz).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port rx_data_i, input, 8, byte from the UART receiver.
REQ-005 SHALL have port rx_valid_i, input, 1, rx_data_i valid.
REQ-006 SHALL have port rx_ready_o, output, 1, the parser accepts a byte when rx_valid_i && rx_ready_o.
REQ-007 SHALL have port tx_data_o, output, 8, byte to the UART transmitter.
REQ-008 SHALL have port tx_valid_o, output, 1, tx_data_o valid.
REQ-009 SHALL have port tx_ready_i, input, 1, the transmitter takes a byte when tx_valid_o && tx_ready_i.
REQ-010 SHALL have port err_o, output, 1, a one-cycle pulse on a malformed or timed-out frame.

Function
REQ-011 Frame format SHALL be: opcode byte, then LEN_LO, then LEN_HI (16-bit payload byte count, little-endian), then LEN payload bytes.
REQ-012 Opcodes SHALL be: 0xEC ECHO, 0xAD ADD, 0x88 MUL (see REQ-030/031); any other opcode is unknown.
REQ-013 State machine states SHALL be: IDLE, LEN_LO, LEN_HI, OPERAND, ECHO_FWD, RESULT_TX, DRAIN.
REQ-014 Transitions SHALL be: IDLE -> LEN_LO on the opcode byte; LEN_LO -> LEN_HI on the next byte; LEN_HI dispatches on the final length byte per REQ-015..017.
REQ-015 ECHO SHALL go to ECHO_FWD when LEN>0 and to IDLE when LEN=0, with no output in the LEN=0 case.
REQ-016 ADD/MUL SHALL go to OPERAND when LEN is nonzero and LEN%4=0; otherwise it pulses err_o and goes to DRAIN (or to IDLE when LEN=0).
REQ-017 An unknown opcode SHALL pulse err_o and go to DRAIN (or to IDLE when LEN=0).
REQ-018 DRAIN SHALL accept and discard exactly LEN bytes, then return to IDLE.
REQ-019 rx_ready_o SHALL be 1 in IDLE, LEN_LO, LEN_HI, OPERAND and DRAIN, and 0 in RESULT_TX.
REQ-020 In OPERAND, bytes SHALL assemble into 32-bit little-endian words; on each word's 4th byte: first word -> acc=word; later words -> acc=acc+word (ADD) or acc=low32(acc*word) (MUL), both mod 2^32.
REQ-021 On the last payload byte, OPERAND SHALL go to RESULT_TX; tx_valid_o rises in the next cycle carrying acc[7:0].
REQ-022 RESULT_TX SHALL emit acc as 4 bytes, LSB first, then go to IDLE after the 4th handshake.
REQ-023 tx_data_o SHALL remain stable while tx_valid_o && !tx_ready_i.
REQ-024 ECHO_FWD SHALL use a one-entry output register, with rx_ready_o = !tx_valid_o || tx_ready_i (combinational path permitted).
REQ-025 In ECHO_FWD, an accepted byte SHALL appear on tx_data_o with tx_valid_o the cycle after acceptance; full throughput under continuous ready; return to IDLE once LEN bytes are forwarded and the last byte has been taken.
REQ-026 Timeout counter SHALL clear on every accepted byte and count cycles with rx_ready_o=1 && !rx_valid_i in LEN_LO, LEN_HI, OPERAND, ECHO_FWD and DRAIN.
REQ-027 When the timeout counter reaches TIMEOUT_CYCLES: pulse err_o, discard the partial frame, go to IDLE. In ECHO_FWD, an already-registered byte still completes.
REQ-028 The timeout counter SHALL never count in IDLE or RESULT_TX.

Reset
REQ-029 Reset SHALL force: state=IDLE; tx_valid_o=0, tx_data_o=0, err_o=0, rx_ready_o=1 after reset; acc, counters and LEN cleared; any in-flight frame or result discarded, with tx_valid_o dropping at the reset edge.

Configuration
REQ-030 With ALU_MUL_EN defined, opcode 0x88 SHALL perform MUL per REQ-020.
REQ-031 Without ALU_MUL_EN, 0x88 SHALL be an unknown opcode (err_o, DRAIN) and no multiplier SHALL be synthesized.

Structure
REQ-032 Shared package alu_uart_pkg SHALL hold: opcode localparams (OP_ECHO, OP_ADD, OP_MUL), the state enum typedef, and the word-width constant.
REQ-033 Combinational operation SHALL live in sub-module alu_op_unit (op, acc, word -> result), with MUL under ALU_MUL_EN.

Verification
REQ-034 ADD: AD 08 00 01 00 00 00 02 00 00 00 -> tx bytes 03 00 00 00, err_o never pulses.
REQ-035 MUL (ALU_MUL_EN): 88 08 00 FF FF FF FF 02 00 00 00 -> FE FF FF FF; without the macro -> err_o pulse, no tx, and a following ECHO frame works.
REQ-036 ECHO with tx_ready_i toggling every other cycle: EC 03 00 41 42 43 -> 41 42 43 in order, no loss or duplication, tx_data_o stable while stalled.
REQ-037 Malformed: AD 03 00 11 22 33 -> err_o pulse, 3 bytes drained, then EC 01 00 55 -> 55.
REQ-038 Timeout (TIMEOUT_CYCLES=50): AD 04 00 01 then 60-cycle gap -> err_o pulse at cycle 50, IDLE, next byte treated as opcode.
REQ-039 Reset asserted during RESULT_TX after 2 bytes sent -> tx_valid_o=0 the next cycle, no further bytes, next frame parsed correctly.
